// File: rtl/result_drain.sv
// result_drain: drains an inclusive address range from a pair of side-by-side
// SRAM macros (A = upper half, B = lower half) onto a valid/ready stream.
//
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   start_i                one-cycle drain request (accepted only in IDLE)
//   rd_start_addr_i        first address of the range
//   rd_end_addr_i          last address of the range (inclusive)
//   csb1_o, addr1_o        shared port-1 chip select (active low) / address
//   dout1_a_i, dout1_b_i   read data, valid one cycle after the read
//   m_valid_o/m_ready_i    output handshake
//   m_data_o, m_last_o     {A,B} result word and end-of-range marker
//   busy_o, done_o         not-IDLE flag, one-cycle completion pulse
//
// Optional feature macro: RESULT_DRAIN_CHKSUM_EN adds chksum_o, the running
// modulo-2^(2*DATA_W) sum of every transferred beat.
module result_drain #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     rd_start_addr_i,
  input  logic [ADDR_W-1:0]     rd_end_addr_i,
  output logic                  csb1_o,
  output logic [ADDR_W-1:0]     addr1_o,
  input  logic [DATA_W-1:0]     dout1_a_i,
  input  logic [DATA_W-1:0]     dout1_b_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [2*DATA_W-1:0]   m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef RESULT_DRAIN_CHKSUM_EN
  , output logic [2*DATA_W-1:0] chksum_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e state_q, state_d;

  // One extra bit so an end address of all-ones terminates instead of wrapping.
  logic [ADDR_W:0] nxt_q, nxt_d, end_q, end_d;

  logic inflt_q, inflt_last_q;

  logic [2*DATA_W-1:0] fdata_q [3];
  logic [2:0]          flast_q;
  logic [1:0]          wptr_q, rptr_q, cnt_q;

  logic issue, push, pop, start_acc;
  logic [2:0] occ;

  // Credit check counts the read whose data lands next edge, so the FIFO
  // can never overflow.
  assign occ   = {1'b0, cnt_q} + {2'b0, inflt_q};
  assign issue = (state_q == S_RUN) && (nxt_q <= end_q) && (occ < 3'd3);
  assign push  = inflt_q;
  assign pop   = m_valid_o && m_ready_i;

  assign csb1_o    = ~issue;
  assign addr1_o   = issue ? nxt_q[ADDR_W-1:0] : '0;
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = m_valid_o ? fdata_q[rptr_q] : '0;
  assign m_last_o  = m_valid_o & flast_q[rptr_q];
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_FIN);

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    end_d     = end_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        start_acc = 1'b1;
        nxt_d     = {1'b0, rd_start_addr_i};
        end_d     = {1'b0, rd_end_addr_i};
        state_d   = (rd_end_addr_i < rd_start_addr_i) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        if (issue) nxt_d = nxt_q + 1'b1;
        if (pop && m_last_o) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      nxt_q        <= '0;
      end_q        <= '0;
      inflt_q      <= 1'b0;
      inflt_last_q <= 1'b0;
      flast_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < 3; i++) fdata_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      nxt_q        <= nxt_d;
      end_q        <= end_d;
      inflt_q      <= issue;
      inflt_last_q <= issue && (nxt_q == end_q);
      if (push) begin
        fdata_q[wptr_q] <= {dout1_a_i, dout1_b_i};
        flast_q[wptr_q] <= inflt_last_q;
        wptr_q          <= inc3(wptr_q);
      end
      if (pop) rptr_q <= inc3(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef RESULT_DRAIN_CHKSUM_EN
  logic [2*DATA_W-1:0] sum_q;
  assign chksum_o = sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (pop)       sum_q <= sum_q + m_data_o;
  end
`endif

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] sa = '0, ea = '0;
  logic csb;
  logic [AW-1:0] addr;
  logic [DW-1:0] da = '0, db = '0;
  logic mv, mr = 1'b0, ml, busy, done;
  logic [2*DW-1:0] md;
`ifdef RESULT_DRAIN_CHKSUM_EN
  logic [2*DW-1:0] chk;
  logic [2*DW-1:0] chk_at_done;
`endif

  int tests = 0, fails = 0;
  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];

  result_drain #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .rd_start_addr_i(sa), .rd_end_addr_i(ea),
    .csb1_o(csb), .addr1_o(addr), .dout1_a_i(da), .dout1_b_i(db),
    .m_valid_o(mv), .m_ready_i(mr), .m_data_o(md), .m_last_o(ml),
    .busy_o(busy), .done_o(done)
`ifdef RESULT_DRAIN_CHKSUM_EN
    , .chksum_o(chk)
`endif
  );

  always #5 clk = ~clk;

  // SRAM pair: one-cycle read latency on port 1.
  always @(posedge clk) if (!csb) begin
    da <= mem_a[addr];
    db <= mem_b[addr];
  end

  // Drain [s..e] and check against the range-derived reference.
  // mode 0: ready high, 1: ready toggling, 2: random ready + stray start pulses.
  // stop_beats > 0 returns early once that many beats have been accepted.
  task automatic drain(input int s, input int e, input int mode, input int stop_beats);
    logic [2*DW-1:0] q[$];
    logic [2*DW-1:0] exp_d, sum, pd;
    int nrd, nbt, c, first_c, last_c, exp_rd, n;
    bit pv, pr, fin, tmo;
    nrd = 0; nbt = 0; c = 0; first_c = -1; last_c = -1; exp_rd = s;
    pv = 0; pr = 0; pd = '0; fin = 0; tmo = 0; sum = '0;
    n = (e >= s) ? e - s + 1 : 0;
    for (int a = s; a <= e; a++) q.push_back({mem_a[a], mem_b[a]});
    @(posedge clk); #1;
    start = 1'b1; sa = s[AW-1:0]; ea = e[AW-1:0];
    mr = (mode == 2) ? 1'($urandom % 2) : 1'b1;
    while (!fin) begin
      @(negedge clk);
      if (c > 0) begin
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy c=%0d got=%b exp=1", c, busy); end
      end
      if (!csb) begin
        tests++;
        if (c == 0 || exp_rd > e || addr !== exp_rd[AW-1:0]) begin
          fails++; $display("FAIL rd_addr c=%0d got=%h exp=%h", c, addr, exp_rd);
        end
        exp_rd++; nrd++;
        tests++;
        if (nrd - nbt > 3) begin fails++; $display("FAIL outstanding got=%0d exp<=3", nrd - nbt); end
      end
      if (pv && !pr) begin
        tests++;
        if (mv !== 1'b1 || md !== pd) begin
          fails++; $display("FAIL stall_hold c=%0d got=%h/%b exp=%h/1", c, md, mv, pd);
        end
      end
      if (mv) begin
        if (first_c < 0) first_c = c;
        if (mr) begin
          tests++;
          if (q.size() == 0) begin
            fails++; $display("FAIL extra_beat got=%h exp=none", md);
          end else begin
            exp_d = q.pop_front();
            if (md !== exp_d || ml !== (q.size() == 0)) begin
              fails++; $display("FAIL beat %0d got=%h last=%b exp=%h last=%b", nbt, md, ml, exp_d, q.size() == 0);
            end
          end
          sum += md; nbt++;
          if (ml) last_c = c;
        end
      end
      if (done) begin
        tests++;
        if (c !== ((n == 0) ? 1 : last_c + 1) || nrd != n || nbt != n) begin
          fails++; $display("FAIL done c=%0d reads=%0d beats=%0d exp_reads=%0d", c, nrd, nbt, n);
        end
`ifdef RESULT_DRAIN_CHKSUM_EN
        chk_at_done = chk;
        tests++;
        if (chk !== sum) begin fails++; $display("FAIL chksum got=%h exp=%h", chk, sum); end
`endif
        fin = 1;
      end
      pv = mv; pr = mr; pd = md;
      if (stop_beats > 0 && nbt == stop_beats) return;
      if (c > 300) begin
        fails++; tests++; $display("FAIL timeout c=%0d beats=%0d exp=%0d", c, nbt, n);
        fin = 1; tmo = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 1) mr = ~mr;
      else if (mode == 2) begin
        mr = 1'($urandom % 2);
        if ($urandom % 4 == 0 && !fin) begin
          start = 1'b1; sa = AW'($urandom); ea = AW'($urandom);
        end
      end
      c++;
    end
    if (!tmo && mode == 0 && n > 0) begin
      tests++;
      if (first_c != 3) begin fails++; $display("FAIL first_latency got=%0d exp=3", first_c); end
    end
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || csb !== 1'b1 || mv !== 1'b0) begin
      fails++; $display("FAIL post_done done=%b busy=%b csb=%b valid=%b exp=0/0/1/0", done, busy, csb, mv);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (csb !== 1'b1 || addr !== '0 || mv !== 1'b0 || ml !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || md !== '0) begin
      fails++; $display("FAIL reset_state csb=%b addr=%h v=%b l=%b busy=%b done=%b d=%h", csb, addr, mv, ml, busy, done, md);
    end
`ifdef RESULT_DRAIN_CHKSUM_EN
    tests++;
    if (chk !== '0) begin fails++; $display("FAIL reset_chksum got=%h exp=0", chk); end
`endif
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      mem_a[16 + i] = 32'hA0 + i; mem_b[16 + i] = 32'hB0 + i;
    end
    drain(16'h10, 16'h13, 0, 0);
  endtask

  task automatic test_stall();
    drain(16'h20, 16'h27, 1, 0);
  endtask

  task automatic test_empty();
    drain(5, 4, 0, 0);
  endtask

  task automatic test_top_range();
    drain(16'h1FE, 16'h1FF, 0, 0);
  endtask

  task automatic test_reset_mid();
    drain(16'h30, 16'h35, 0, 2);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (csb !== 1'b1 || mv !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rst_mid csb=%b v=%b done=%b busy=%b exp=1/0/0/0", csb, mv, done, busy);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    drain(0, 1, 0, 0);
  endtask

  task automatic test_chksum();
`ifdef RESULT_DRAIN_CHKSUM_EN
    mem_a[16'h40] = '0; mem_b[16'h40] = 32'd1;
    mem_a[16'h41] = '0; mem_b[16'h41] = 32'd2;
    mem_a[16'h42] = '1; mem_b[16'h42] = '1;
    drain(16'h40, 16'h42, 2, 0);
    tests++;
    if (chk_at_done !== 64'd2) begin fails++; $display("FAIL chksum_wrap got=%h exp=2", chk_at_done); end
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      int s, len;
      len = $urandom_range(1, 12);
      s   = $urandom_range(0, 511 - len);
      drain(s, s + len - 1, (k % 2 == 0) ? 2 : 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = $urandom; mem_b[i] = $urandom;
    end
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_top_range();
    test_reset_mid();
    test_chksum();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, width of one SRAM macro word.
REQ-003 SHALL have port clk_i  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle request to begin a drain.
REQ-006 SHALL have port rd_start_addr_i  input  ADDR_W  first result address.
REQ-007 SHALL have port rd_end_addr_i  input  ADDR_W  last result address, inclusive.
REQ-008 SHALL have port csb1_o  output  1  active-low chip select, shared by port 1 of both SRAMs.
REQ-009 SHALL have port addr1_o  output  ADDR_W  read address, shared by port 1 of both SRAMs.
REQ-010 SHALL have port dout1_a_i  input  DATA_W  upper-half read data, from SRAM A.
REQ-011 SHALL have port dout1_b_i  input  DATA_W  lower-half read data, from SRAM B.
REQ-012 SHALL have port m_valid_o  output  1  output beat valid.
REQ-013 SHALL have port m_ready_i  input  1  downstream ready.
REQ-014 SHALL have port m_data_o  output  2*DATA_W  result: {dout1_a_i, dout1_b_i}.
REQ-015 SHALL have port m_last_o  output  1  marks the beat read from rd_end_addr_i.
REQ-016 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse when a drain completes.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and FIN.
REQ-019 In IDLE, start_i SHALL latch both addresses and go to RUN, or go to FIN when rd_end_addr_i < rd_start_addr_i.
REQ-020 SHALL ignore start_i in any state other than IDLE.
REQ-021 SRAM read latency SHALL be exactly 1 cycle: data for an address presented with csb1_o=0 in cycle N is sampled in cycle N+1.
REQ-022 SHALL buffer returned data in a 3-entry FIFO.
REQ-023 SHALL issue a read only when FIFO occupancy + reads in flight < 3 and addresses remain; otherwise csb1_o=1.
REQ-024 Addresses SHALL be issued in ascending order, each exactly once.
REQ-025 The issue counter SHALL be ADDR_W+1 bits wide so that rd_end_addr_i = 2^ADDR_W-1 terminates without wrap-around.
REQ-026 m_valid_o SHALL equal FIFO non-empty; a beat transfers when m_valid_o && m_ready_i.
REQ-027 m_data_o and m_last_o SHALL stay stable while m_valid_o && !m_ready_i.
REQ-028 The first beat SHALL be valid 3 cycles after the start_i cycle.
REQ-029 With m_ready_i held high, SHALL sustain 1 beat per cycle.
REQ-030 RUN SHALL go to FIN in the cycle the m_last_o beat transfers.
REQ-031 FIN SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-032 An empty range (REQ-019) SHALL produce zero beats, zero reads, and a done_o pulse 1 cycle after start_i.

Reset
REQ-033 While rst_i is high: state=IDLE, FIFO empty, in-flight count 0, csb1_o=1, addr1_o=0, m_valid_o=0, m_last_o=0, busy_o=0, done_o=0, m_data_o=0.
REQ-034 Reset asserted mid-drain SHALL discard all buffered and in-flight data, with no done_o pulse.
REQ-035 Returning SRAM data SHALL be dropped after reset; the first start_i after reset SHALL behave as from a cold reset.

Configuration
REQ-036 With RESULT_DRAIN_CHKSUM_EN defined, SHALL add output chksum_o (2*DATA_W): the modulo-2^(2*DATA_W) sum of all transferred m_data_o beats, cleared on start_i acceptance and on reset, and final and stable while done_o is high.
REQ-037 Without RESULT_DRAIN_CHKSUM_EN, chksum_o and its adder SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-038 Range 0x10..0x13, ready=1, SRAM A/B preloaded with 0xA0+i and 0xB0+i -> 4 beats on consecutive cycles, first 3 cycles after start, data {0xA0,0xB0}..{0xA3,0xB3}, m_last_o on beat 4, done_o next cycle.
REQ-039 Range 0x20..0x27, m_ready_i toggled 1-0-1-0 -> 8 beats in order; data held stable while stalled; never more than 3 reads outstanding-plus-buffered.
REQ-040 start 5, end 4 -> no csb1_o=0 cycle, no beats, done_o one cycle after start.
REQ-041 Range 0x1FE..0x1FF (ADDR_W=9) -> exactly 2 reads, no read of address 0, m_last_o on the 0x1FF beat.
REQ-042 rst_i asserted after beat 2 of 6, then a new start with range 0..1 -> only 2 beats of the new range, csb1_o=1 during reset.
REQ-043 With RESULT_DRAIN_CHKSUM_EN defined, beats 1, 2, 0xFFFFFFFFFFFFFFFF -> chksum_o=2 at done_o.
